// File: rtl/button_pkg.sv
// button_pkg: debouncer state encoding and timer sizing helper
package button_pkg;
  typedef enum logic [1:0] {IDLE, ARMING, HELD, DISARMING} btn_state_t;
  function automatic int calc_cnt_max(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction
endpackage

// File: rtl/button_debouncer_sync.sv
// bit_synchronizer: plain flop chain bringing an async input into the clock domain
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r_chain;
  if (STAGES < 2) begin : g_bad_stages
    $error("bit_synchronizer needs at least 2 stages");
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_chain <= '0;
    else r_chain <= {r_chain[STAGES-2:0], d};
  assign q = r_chain[STAGES-1];
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a raw button and qualifies each level change with a stability timer
module button_debouncer
  import button_pkg::*;
#(
  parameter int CLK_HZ         = 12_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int SYNC_STAGES    = 2,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic clk_12m,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic bouncing
);
  localparam int CNT_MAX = calc_cnt_max(CLK_HZ, DEBOUNCE_MS);
  localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  if (CNT_MAX < 1) begin : g_bad_cnt
    $error("debounce interval must be at least one clock");
  end
  btn_state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic w_d, w_s;
  // inverting before the chain lets its reset value mean "not pressed" for either polarity
  assign w_d = btn_raw ^ BTN_ACTIVE_LOW;
  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk_12m),
    .rst(rst),
    .d(w_d),
    .q(w_s)
  );
  always_ff @(posedge clk_12m or posedge rst)
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      bouncing      <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (r_state)
        IDLE: if (w_s) begin
          r_state  <= ARMING;
          r_cnt    <= '0;
          bouncing <= 1'b1;
        end
        ARMING: if (!w_s) begin
          r_state  <= IDLE;
          bouncing <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          r_state     <= HELD;
          btn_level   <= 1'b1;
          press_pulse <= 1'b1;
          bouncing    <= 1'b0;
        end else r_cnt <= r_cnt + CNT_W'(1);
        HELD: if (!w_s) begin
          r_state  <= DISARMING;
          r_cnt    <= '0;
          bouncing <= 1'b1;
        end
        DISARMING: if (w_s) begin
          r_state  <= HELD;
          bouncing <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          r_state       <= IDLE;
          btn_level     <= 1'b0;
          release_pulse <= 1'b1;
          bouncing      <= 1'b0;
        end else r_cnt <= r_cnt + CNT_W'(1);
      endcase
    end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed checks of both polarities with CNT_MAX=4, two sync stages
module tb_button_debouncer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_a = 1'b0;
  logic raw_b = 1'b1;
  logic lvl_a, prs_a, rel_a, bnc_a;
  logic lvl_b, prs_b, rel_b, bnc_b;
  int n_assert = 0;
  int n_fail = 0;
  int np_a = 0, nr_a = 0, nb_a = 0, np_b = 0, nr_b = 0;
  int p0, r0, b0;
  button_debouncer #(.CLK_HZ(1000), .DEBOUNCE_MS(4), .SYNC_STAGES(2), .BTN_ACTIVE_LOW(1'b0)) u_a (
    .clk_12m(clk), .rst(rst), .btn_raw(raw_a),
    .btn_level(lvl_a), .press_pulse(prs_a), .release_pulse(rel_a), .bouncing(bnc_a)
  );
  button_debouncer #(.CLK_HZ(1000), .DEBOUNCE_MS(4), .SYNC_STAGES(2), .BTN_ACTIVE_LOW(1'b1)) u_b (
    .clk_12m(clk), .rst(rst), .btn_raw(raw_b),
    .btn_level(lvl_b), .press_pulse(prs_b), .release_pulse(rel_b), .bouncing(bnc_b)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (prs_a) np_a++;
    if (rel_a) nr_a++;
    if (bnc_a) nb_a++;
    if (prs_b) np_b++;
    if (rel_b) nr_b++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    #1;
    check("rst lvl_a", lvl_a, 0);
    check("rst prs_a", prs_a, 0);
    check("rst rel_a", rel_a, 0);
    check("rst bnc_a", bnc_a, 0);
    check("rst lvl_b", lvl_b, 0);
    check("rst bnc_b", bnc_b, 0);
    repeat (3) tick();
    rst = 1'b0;
    // glitches of 1, 2, 3 cycles: each arms the timer but never completes it
    p0 = np_a; r0 = nr_a; b0 = nb_a;
    for (int k = 1; k <= 3; k++) begin
      raw_a = 1'b1;
      repeat (k) tick();
      raw_a = 1'b0;
      repeat (5) tick();
    end
    check("glitch lvl", lvl_a, 0);
    check("glitch press", np_a - p0, 0);
    check("glitch release", nr_a - r0, 0);
    check("glitch bouncing cycles", nb_a - b0, 6);
    // clean press
    raw_a = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      tick();
      check($sformatf("clean press i=%0d", i), prs_a, (i == 6));
      check($sformatf("clean lvl i=%0d", i), lvl_a, (i >= 6));
      check($sformatf("clean bnc i=%0d", i), bnc_a, (i >= 2 && i <= 5));
    end
    // bouncy release: 0,1,0,1,0,1 then held 0
    r0 = nr_a;
    for (int i = 0; i <= 14; i++) begin
      raw_a = (i <= 5) ? logic'(i % 2) : 1'b0;
      tick();
      check($sformatf("bouncy rel i=%0d", i), rel_a, (i == 12));
      check($sformatf("bouncy rel lvl i=%0d", i), lvl_a, (i < 12));
    end
    check("bouncy release count", nr_a - r0, 1);
    // bouncy press: toggle for 10 cycles ending on 1, then held 1
    p0 = np_a;
    for (int i = 0; i <= 17; i++) begin
      raw_a = (i <= 9) ? logic'(i % 2) : 1'b1;
      tick();
      check($sformatf("bouncy press i=%0d", i), prs_a, (i == 15));
      check($sformatf("bouncy press lvl i=%0d", i), lvl_a, (i >= 15));
    end
    check("bouncy press count", np_a - p0, 1);
    raw_a = 1'b0;
    repeat (8) tick();
    check("released lvl", lvl_a, 0);
    // async reset while ARMING with cnt=2
    r0 = nr_a;
    raw_a = 1'b1;
    repeat (5) tick();
    check("arming bnc", bnc_a, 1);
    rst = 1'b1;
    #2;
    check("async rst bnc", bnc_a, 0);
    check("async rst lvl", lvl_a, 0);
    check("async rst prs", prs_a, 0);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      tick();
      check($sformatf("post-rst press i=%0d", i), prs_a, (i == 6));
      check($sformatf("post-rst lvl i=%0d", i), lvl_a, (i >= 6));
    end
    check("post-rst no release", nr_a - r0, 0);
    // active-low instance: idle-high pad and resets must not have strobed
    check("low idle press", np_b, 0);
    check("low idle release", nr_b, 0);
    check("low idle lvl", lvl_b, 0);
    raw_b = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      tick();
      check($sformatf("low press i=%0d", i), prs_b, (i == 6));
      check($sformatf("low lvl i=%0d", i), lvl_b, (i >= 6));
      check($sformatf("low bnc i=%0d", i), bnc_b, (i >= 2 && i <= 5));
    end
    check("low press count", np_b, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
